fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch stage that sits directly upstream of the IF/ID pipeline register and replaces direct PC-to-instruction-memory fetch.
- Owns the fetch PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {instr, pc_plus_4} to IF/ID with valid/ready.
- Flushes on branch/jump redirect, discarding in-flight and queued instructions.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-low reset (0 = reset)
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  word address of request, stable while imem_req=1
imem_ack  in  1  request accepted and imem_rdata valid this cycle
imem_rdata  in  32  returned instruction
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new fetch PC (bits [1:0] ignored, treated as 0)
out_valid  out  1  queue head valid
out_ready  in  1  IF/ID accepting (enable)
out_instr  out  32  head instruction
out_pc_plus4  out  32  head fetch address + 4

Behaviour:
- Reset (reset=0 at clk edge): count=0, rd/wr pointers=0, fetch_pc=RESET_PC, state=IDLE; imem_req=0, out_valid=0, out_instr=0, out_pc_plus4=0.
- FIFO: entry = {instr, pc+4}. count width clog2(DEPTH)+1; pointers wrap modulo DEPTH. out_valid = (count!=0); out_* are the head entry, or 0 when empty.
- Pop when out_valid & out_ready. Push when imem_ack is accepted in state REQ with no redirect that cycle. Simultaneous push and pop leave count unchanged.
- One outstanding request maximum. The issue condition "room" is defined as count < DEPTH, evaluated on registered count.
- FSM:
  - IDLE: imem_req=0. If room and no redirect -> REQ, with imem_addr=fetch_pc latched.
  - REQ: imem_req=1, address held.
    - On ack: push, fetch_pc += 4; -> REQ if count after update < DEPTH, else IDLE.
    - On redirect without ack: -> STALE.
    - On redirect with ack: drop data, fetch_pc = redirect_pc, -> IDLE.
  - STALE: imem_req=1 with the old address (handshake must not be withdrawn). On ack: data dropped -> IDLE. A further redirect only updates fetch_pc.
- Redirect: in the same cycle, FIFO flushed (count=0, pointers=0) and fetch_pc=redirect_pc; any pop that cycle is ignored. The first new request is issued no earlier than the cycle after redirect.
- fetch_pc arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. out_pc_plus4 wraps identically.
- Latency: reset release -> imem_req=1 with addr=RESET_PC on the next cycle. Ack -> out_valid on the following cycle (non-bypass).
- Full FIFO: no request issued; fetch_pc is held.
- Reset asserted mid-request: imem_req drops at the next edge, and any later ack is ignored until re-requested.

Optional Feature:
- FQ_BYPASS_EN: when defined and the FIFO is empty in state REQ with imem_ack=1, the combinational path imem_rdata -> out_instr drives out_valid=1 in the ack cycle.
  - If out_ready=1, the entry is consumed without being pushed.
  - If out_ready=0, the entry is pushed as normal.
  - Redirect in the same cycle suppresses the bypass (out_valid=0).
- Without the macro, all outputs come from registered FIFO state only, with a minimum of 1 cycle from ack to out_valid.

Decomposition:
- Package fetch_queue_pkg:
  - state enum {IDLE, REQ, STALE}
  - INSTR_W=32, PC_INC=32'd4
  - fq_entry_t struct {instr, pc_plus4}
- Sub-module fq_ring_buffer holds storage, pointers, count, push/pop/flush, full/empty.
- Top holds the FSM, fetch_pc and bypass.

Test Plan:
- Reset release, imem_ack tied 1, out_ready=1 -> out_instr sequence matches memory at 0,4,8,...; out_pc_plus4 = 4,8,12; one instruction per cycle after 2-cycle startup.
- out_ready=0, ack always 1, DEPTH=4 -> exactly 4 requests (addr 0..C), then imem_req=0. Raise out_ready -> requests resume at addr 0x10.
- Ack delayed 3 cycles on addr 0x8 -> imem_addr stays 0x8 and imem_req stays 1 for all 3 cycles; no duplicate push.
- Redirect to 0x100 while REQ at 0x8 is waiting -> FIFO empty next cycle. The 0x8 ack data never appears; next request addr is 0x100, and the first output has pc_plus4=0x104.
- Redirect to 0x40 in the same cycle as ack and pop with count=2 -> count=0, data dropped, next request 0x40.
- Redirect to 32'hFFFF_FFFC -> requests FFFF_FFFC then 0000_0000; out_pc_plus4 = 0 then 4. Under FQ_BYPASS_EN, with an empty FIFO, ack and out_ready -> out_valid in the same cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the fetch queue
package fetch_queue_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALE = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - imem request, redirect and IF/ID output bundle of the fetch queue
interface fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc_plus4,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc_plus4,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fq_ring_buffer.sv
// rtl/fq_ring_buffer.sv - power-of-two ring buffer of {instr, pc_plus4} with flush
module fq_ring_buffer
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fq_entry_t        i_wdata,
  output fq_entry_t        o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Flush wins over any push/pop issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with redirect flush
// Optional FQ_BYPASS_EN: imem_rdata feeds the output in the ack cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_fetch_pc;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_ack_live;
  logic             w_bypass;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_after;
  logic [31:0]      w_redirect_pc;
  fq_entry_t        w_head;
  fq_entry_t        w_wdata;

  assign w_redirect_pc = bus.redirect_pc & ~32'd3;
  assign w_ack_live    = (r_state == REQ) && bus.imem_ack && !bus.redirect_valid;

`ifdef FQ_BYPASS_EN
  assign w_bypass = w_ack_live && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop            = !w_empty && bus.out_ready && !bus.redirect_valid;
  assign w_push           = w_ack_live && !(w_bypass && bus.out_ready);
  assign w_wdata.instr    = bus.imem_rdata;
  assign w_wdata.pc_plus4 = r_addr + PC_INC;
  assign w_count_after    = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  fq_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // STALE keeps the old request up until memory acks it, then drops the data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      if (bus.redirect_valid) r_fetch_pc <= w_redirect_pc;
      case (r_state)
        IDLE: begin
          if (!bus.redirect_valid && !w_full) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if (bus.redirect_valid) begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end else begin
              r_fetch_pc <= r_fetch_pc + PC_INC;
              if (w_count_after < CNT_W'(DEPTH)) begin
                r_addr <= r_fetch_pc + PC_INC;
              end else begin
                r_state <= IDLE;
                r_req   <= 1'b0;
              end
            end
          end else if (bus.redirect_valid) begin
            r_state <= STALE;
          end
        end
        STALE: begin
          if (bus.imem_ack) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = r_req;
  assign bus.imem_addr    = r_addr;
  assign bus.out_valid    = !w_empty || w_bypass;
  assign bus.out_instr    = w_bypass ? bus.imem_rdata : w_head.instr;
  assign bus.out_pc_plus4 = w_bypass ? w_wdata.pc_plus4 : w_head.pc_plus4;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (vector table, corner sequences, random vs queue model)
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int NV    = 15;
`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  typedef struct {
    logic        rdy;
    logic        ack;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic rdy, input logic ack, input logic rdr,
                         input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                         input logic e_val, input logic [31:0] e_pc4);
    vecs[i].rdy = rdy;     vecs[i].ack = ack;       vecs[i].rdr = rdr;     vecs[i].rpc = rpc;
    vecs[i].e_req = e_req; vecs[i].e_addr = e_addr; vecs[i].e_val = e_val; vecs[i].e_pc4 = e_pc4;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  // Free-running ack=1/ready=1 window: requests and outputs must walk up from base.
  task automatic run_stream(input string tag, input int cycles, input logic [31:0] base, input int exp_outs);
    int k = 0;
    int j = 0;
    bus.imem_ack = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (bus.imem_req && bus.imem_ack) begin
        chk({tag, "_req_addr"}, bus.imem_addr, base + 32'(4 * j));
        j++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk({tag, "_pc4"}, bus.out_pc_plus4, base + 32'(4 * (k + 1)));
        chk({tag, "_instr"}, bus.out_instr, mem_word(base + 32'(4 * k)));
        k++;
      end
      tick;
    end
    chk({tag, "_count"}, 32'(k), 32'(exp_outs));
  endtask

  logic [31:0] q [$];
  logic [31:0] nf;
  logic [31:0] head;
  logic [31:0] prev_addr;
  logic        prev_req;
  logic        prev_ack;
  logic        live;
  logic        byp;
  bit          stale;
  int          pops;

  initial begin
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;

    // Fill to full with out_ready=0, drain, then redirect with ack+pop at count=2.
    set_vec( 0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0);
    set_vec( 1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0);
    set_vec( 2, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  1'b1, 32'h4);
    set_vec( 3, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h4);
    set_vec( 4, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 32'h4);
    set_vec( 5, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4);
    set_vec( 6, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4);
    set_vec( 7, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h4);
    set_vec( 8, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h8);
    set_vec( 9, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'hC);
    set_vec(10, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'h10);
    set_vec(11, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h18, 1'b1, 32'h14);
    set_vec(12, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0);
    set_vec(13, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0);
    set_vec(14, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h44);
`ifdef FQ_BYPASS_EN
    set_vec( 1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  1'b1, 32'h4);
    set_vec(13, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 32'h44);
    set_vec(14, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h48);
`endif

    do_reset;
    for (int i = 0; i < NV; i++) begin
      bus.out_ready = vecs[i].rdy;
      bus.imem_ack = vecs[i].ack;
      bus.redirect_valid = vecs[i].rdr;
      bus.redirect_pc = vecs[i].rpc;
      #1;
      chk1($sformatf("vec%0d_req", i), bus.imem_req, vecs[i].e_req);
      if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      chk1($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_val);
      chk($sformatf("vec%0d_pc4", i), bus.out_pc_plus4, vecs[i].e_pc4);
      chk($sformatf("vec%0d_instr", i), bus.out_instr,
          vecs[i].e_val ? mem_word(vecs[i].e_pc4 - 32'd4) : 32'h0);
      tick;
    end

    do_reset;
    run_stream("stream", 12, 32'h0, BYP ? 11 : 10);

    // Ack held off three cycles on 0x8: address and request stay put, one push only.
    do_reset;
    bus.imem_ack = 1'b1;
    tick;
    tick;
    tick;
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, 32'h8);
      tick;
    end
    bus.imem_ack = 1'b1;
    #1;
    chk("wait_ack_addr", bus.imem_addr, 32'h8);
    tick;
    bus.imem_ack = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk1("after_wait_req", bus.imem_req, 1'b1);
    chk("after_wait_addr", bus.imem_addr, 32'hC);
    for (int i = 0; i < 3; i++) begin
      if (i != 0) #1;
      chk1("drain_valid", bus.out_valid, 1'b1);
      chk("drain_pc4", bus.out_pc_plus4, 32'(4 * (i + 1)));
      tick;
    end
    #1;
    chk1("drain_empty", bus.out_valid, 1'b0);

    // Redirect while the 0xC request is pending: it turns stale and its data is dropped.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    tick;
    bus.redirect_valid = 1'b0;
    #1;
    chk1("stale_req", bus.imem_req, 1'b1);
    chk("stale_addr", bus.imem_addr, 32'hC);
    chk1("stale_valid", bus.out_valid, 1'b0);
    tick;
    bus.imem_ack = 1'b1;
    #1;
    chk("stale_ack_addr", bus.imem_addr, 32'hC);
    tick;
    #1;
    chk1("post_stale_req", bus.imem_req, 1'b0);
    chk1("post_stale_valid", bus.out_valid, 1'b0);
    tick;
    bus.out_ready = 1'b0;
    #1;
    chk1("redir_req", bus.imem_req, 1'b1);
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk1("redir_ack_cycle_valid", bus.out_valid, BYP);
    tick;
    bus.imem_ack = 1'b0;
    #1;
    chk1("redir_out_valid", bus.out_valid, 1'b1);
    chk("redir_out_pc4", bus.out_pc_plus4, 32'h104);
    chk("redir_out_instr", bus.out_instr, mem_word(32'h100));

    // Redirect near the top of the address space wraps fetch and pc_plus4 to 0.
    do_reset;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    tick;
    run_stream("wrap", 6, 32'hFFFF_FFFC, BYP ? 5 : 4);

    // Reset in the middle of a request drops imem_req; an ack while idle is ignored.
    do_reset;
    tick;
    #1;
    chk1("midrst_req_before", bus.imem_req, 1'b1);
    reset = 1'b0;
    tick;
    #1;
    chk1("midrst_req", bus.imem_req, 1'b0);
    chk1("midrst_valid", bus.out_valid, 1'b0);
    reset = 1'b1;
    bus.imem_ack = 1'b1;
    tick;
    bus.imem_ack = 1'b0;
    #1;
    chk1("midrst_rereq", bus.imem_req, 1'b1);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk1("midrst_no_push", bus.out_valid, 1'b0);

    // Random traffic against an address-stream model: queue of fetched addresses in order.
    do_reset;
    q.delete();
    nf = 32'h0;
    stale = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = 32'h0;
    pops = 0;
    for (int c = 0; c < 2000; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.imem_ack = ($urandom_range(0, 9) < 6);
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      #1;
      live = bus.imem_req && !stale;
      byp = BYP && live && bus.imem_ack && !bus.redirect_valid && (q.size() == 0);
      chk1("rnd_valid", bus.out_valid, (q.size() != 0) || byp);
      if (bus.out_valid) begin
        head = (q.size() != 0) ? q[0] : nf;
        chk("rnd_pc4", bus.out_pc_plus4, head + 32'd4);
        chk("rnd_instr", bus.out_instr, mem_word(head));
      end
      if (prev_req && !prev_ack) begin
        chk1("rnd_req_held", bus.imem_req, 1'b1);
        chk("rnd_addr_held", bus.imem_addr, prev_addr);
      end
      if (live) begin
        chk("rnd_req_addr", bus.imem_addr, nf);
        chk1("rnd_room", q.size() < DEPTH, 1'b1);
      end
      if (bus.redirect_valid) begin
        q.delete();
        nf = bus.redirect_pc & ~32'd3;
        stale = bus.imem_req && !bus.imem_ack;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          pops++;
          if (q.size() != 0) void'(q.pop_front());
        end
        if (bus.imem_req && bus.imem_ack) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            if (!(byp && bus.out_ready)) q.push_back(nf);
            nf = nf + 32'd4;
          end
        end
      end
      prev_req = bus.imem_req;
      prev_ack = bus.imem_ack;
      prev_addr = bus.imem_addr;
      tick;
    end
    chk1("rnd_progress", pops > 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
